// File: rtl/r5p_tcb_arb2.sv
// Two-manager TCB arbiter (IFU = m0, LSU = m1) onto one subordinate port.
// Round-robin on ties, locks a stalled grant, routes responses through a DLY-deep tag pipeline.
module r5p_tcb_arb2 #(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned BW  = DW/8,
   parameter int unsigned DLY = 1
)(
   input  logic          clk,
   input  logic          rst,
   // manager 0 (IFU)
   input  logic          m0_vld,
   input  logic          m0_wen,
   input  logic [AW-1:0] m0_adr,
   input  logic [BW-1:0] m0_ben,
   input  logic [DW-1:0] m0_wdt,
   output logic          m0_rdy,
   output logic [DW-1:0] m0_rdt,
   output logic          m0_err,
   // manager 1 (LSU)
   input  logic          m1_vld,
   input  logic          m1_wen,
   input  logic [AW-1:0] m1_adr,
   input  logic [BW-1:0] m1_ben,
   input  logic [DW-1:0] m1_wdt,
   output logic          m1_rdy,
   output logic [DW-1:0] m1_rdt,
   output logic          m1_err,
   // subordinate
   output logic          s_vld,
   output logic          s_wen,
   output logic [AW-1:0] s_adr,
   output logic [BW-1:0] s_ben,
   output logic [DW-1:0] s_wdt,
   input  logic          s_rdy,
   input  logic [DW-1:0] s_rdt,
   input  logic          s_err
);

   logic gnt;
   logic lst;
   logic lck;
   logic lck_idx;
   logic xfer;
   logic rsp_v;
   logic rsp_idx;

   // NOTE: every branch assigns gnt, so no latch is inferred.
   always_comb begin
      if (lck)                   gnt = lck_idx;
      else if (m0_vld && m1_vld) gnt = ~lst;
      else if (m0_vld)           gnt = 1'b0;
      else if (m1_vld)           gnt = 1'b1;
      else                       gnt = lst;
   end

   assign s_vld = gnt ? m1_vld : m0_vld;
   assign s_wen = gnt ? m1_wen : m0_wen;
   assign s_adr = gnt ? m1_adr : m0_adr;
   assign s_ben = gnt ? m1_ben : m0_ben;
   assign s_wdt = gnt ? m1_wdt : m0_wdt;

   assign m0_rdy = s_rdy & ~gnt & m0_vld;
   assign m1_rdy = s_rdy &  gnt & m1_vld;

   assign xfer = s_vld & s_rdy;

   // A stall locks the current grant; a transfer or a dropped vld releases it.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lst     <= 1'b1;
         lck     <= 1'b0;
         lck_idx <= 1'b0;
      end else begin
         if (xfer) lst <= gnt;
         lck <= s_vld & ~s_rdy;
         if (s_vld && !s_rdy) lck_idx <= gnt;
      end
   end

   generate
      if (DLY == 0) begin : g_comb
         assign rsp_v   = xfer;
         assign rsp_idx = gnt;
      end else begin : g_pipe
         logic [DLY-1:0] pv;
         logic [DLY-1:0] pi;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pv <= '0;
            end else begin
               pv[0] <= xfer;
               for (int i = 1; i < DLY; i++) pv[i] <= pv[i-1];
            end
         end

         // NOTE: index bits are qualified by pv, so they carry no reset.
         always_ff @(posedge clk) begin
            pi[0] <= gnt;
            for (int i = 1; i < DLY; i++) pi[i] <= pi[i-1];
         end

         assign rsp_v   = pv[DLY-1];
         assign rsp_idx = pi[DLY-1];
      end
   endgenerate

   assign m0_rdt = (rsp_v && !rsp_idx) ? s_rdt : '0;
   assign m1_rdt = (rsp_v &&  rsp_idx) ? s_rdt : '0;
   assign m0_err = rsp_v & ~rsp_idx & s_err;
   assign m1_err = rsp_v &  rsp_idx & s_err;

endmodule

// File: tb/tb_r5p_tcb_arb2.sv
// Bench for r5p_tcb_arb2: DLY=0,1,2 instances share stimulus; a rule-level model feeds
// per-instance response scoreboards that an independent monitor drains.
module tb_r5p_tcb_arb2;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW/8;

   typedef struct {
      int due;
      bit idx;
      bit wen;
   } ent_t;

   logic          clk;
   logic          rst;
   logic          mv   [2];
   logic          mw   [2];
   logic [AW-1:0] madr [2];
   logic [BW-1:0] mben [2];
   logic [DW-1:0] mwdt [2];
   logic          s_rdy;
   logic [DW-1:0] s_rdt;
   logic          s_err;

   logic          o_svld [3];
   logic          o_swen [3];
   logic [AW-1:0] o_sadr [3];
   logic [BW-1:0] o_sben [3];
   logic [DW-1:0] o_swdt [3];
   logic          o_rdy0 [3];
   logic          o_rdy1 [3];
   logic [DW-1:0] o_rdt0 [3];
   logic [DW-1:0] o_rdt1 [3];
   logic          o_err0 [3];
   logic          o_err1 [3];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   hold_err = 0;
   bit   done [2] = '{0, 0};

   // reference state: last winner, stalled owner (-1 = none)
   int   last  = 1;
   int   owner = -1;
   ent_t sbq [3][$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      r5p_tcb_arb2 #(.AW(AW), .DW(DW), .BW(BW), .DLY(g)) dut (
         .clk    (clk),
         .rst    (rst),
         .m0_vld (mv[0]),   .m0_wen (mw[0]),   .m0_adr (madr[0]),
         .m0_ben (mben[0]), .m0_wdt (mwdt[0]),
         .m0_rdy (o_rdy0[g]), .m0_rdt (o_rdt0[g]), .m0_err (o_err0[g]),
         .m1_vld (mv[1]),   .m1_wen (mw[1]),   .m1_adr (madr[1]),
         .m1_ben (mben[1]), .m1_wdt (mwdt[1]),
         .m1_rdy (o_rdy1[g]), .m1_rdt (o_rdt1[g]), .m1_err (o_err1[g]),
         .s_vld  (o_svld[g]), .s_wen (o_swen[g]), .s_adr (o_sadr[g]),
         .s_ben  (o_sben[g]), .s_wdt (o_swdt[g]),
         .s_rdy  (s_rdy),   .s_rdt  (s_rdt),   .s_err  (s_err)
      );
   end

   always #5 clk = ~clk;

   task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL cyc%0d dly%0d %s: got %0h expected %0h", cyc, d, name, act, exp);
      end
   endtask

   // Model: decide the grant from the rules, check the request path, log transfers.
   always @(negedge clk) begin : model
      int  g;
      bit  ev;
      cyc++;
      if (rst) begin
         for (int d = 0; d < 3; d++) sbq[d].delete();
         last  = 1;
         owner = -1;
      end
      if (owner >= 0)            g = owner;
      else if (mv[0] && mv[1])   g = 1 - last;
      else if (mv[0])            g = 0;
      else if (mv[1])            g = 1;
      else                       g = last;
      ev = mv[g];
      for (int d = 0; d < 3; d++) begin
         check("s_vld",  d, 64'(o_svld[d]), 64'(ev));
         check("s_wen",  d, 64'(o_swen[d]), 64'(mw[g]));
         check("s_adr",  d, 64'(o_sadr[d]), 64'(madr[g]));
         check("s_ben",  d, 64'(o_sben[d]), 64'(mben[g]));
         check("s_wdt",  d, 64'(o_swdt[d]), 64'(mwdt[g]));
         check("m0_rdy", d, 64'(o_rdy0[d]), 64'(s_rdy && g == 0 && mv[0]));
         check("m1_rdy", d, 64'(o_rdy1[d]), 64'(s_rdy && g == 1 && mv[1]));
      end
      done[0] = 0;
      done[1] = 0;
      if (!rst) begin
         if (ev && s_rdy) begin
            done[g] = 1;
            last    = g;
            owner   = -1;
            for (int d = 0; d < 3; d++) sbq[d].push_back('{due: cyc + d, idx: g[0], wen: mw[g]});
         end else if (ev) begin
            owner = g;
         end else begin
            owner = -1;
         end
      end
   end

   // Monitor: response outputs of each instance against its scoreboard.
   always @(negedge clk) begin : monitor
      ent_t          e;
      bit            hv;
      logic [DW-1:0] er [2];
      logic          ee [2];
      #1;
      for (int d = 0; d < 3; d++) begin
         hv = 0;
         er[0] = '0; er[1] = '0; ee[0] = 0; ee[1] = 0;
         if (sbq[d].size() > 0 && sbq[d][0].due <= cyc) begin
            e  = sbq[d].pop_front();
            hv = 1;
            check("rsp_due", d, 64'(cyc), 64'(e.due));
            er[e.idx] = s_rdt;
            ee[e.idx] = s_err;
         end
         if (!(hv && e.idx == 0 && e.wen)) check("m0_rdt", d, 64'(o_rdt0[d]), 64'(er[0]));
         if (!(hv && e.idx == 1 && e.wen)) check("m1_rdt", d, 64'(o_rdt1[d]), 64'(er[1]));
         check("m0_err", d, 64'(o_err0[d]), 64'(ee[0]));
         check("m1_err", d, 64'(o_err1[d]), 64'(ee[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      s_rdt = $urandom;
      if (!hold_err) s_err = ($urandom_range(0, 3) == 0);
   endtask

   task automatic req(input int i, input bit v, input bit w, input logic [AW-1:0] a);
      mv[i]   = v;
      mw[i]   = w;
      madr[i] = a;
      mben[i] = BW'($urandom);
      mwdt[i] = $urandom;
   endtask

   initial begin
      clk = 0;
      rst = 1;
      s_rdy = 0; s_rdt = '0; s_err = 0;
      req(0, 0, 0, '0);
      req(1, 0, 0, '0);
      repeat (3) tick();
      rst = 0;

      // tie arbitration straight out of reset
      req(0, 1, 0, 32'h10); req(1, 1, 0, 32'h20); s_rdy = 1;
      repeat (4) tick();
      req(0, 0, 0, '0); req(1, 0, 0, '0);
      tick();

      // lock: m1 stalled at 0x100, m0 arrives during the stall
      s_rdy = 0; req(1, 1, 0, 32'h100);
      tick();
      req(0, 1, 0, 32'h200);
      repeat (2) tick();
      s_rdy = 1;
      tick();
      req(1, 0, 0, '0);
      tick();
      req(0, 0, 0, '0);
      tick();

      // back-to-back alternating reads
      req(0, 1, 0, 32'h0);
      tick();
      req(0, 0, 0, '0); req(1, 1, 0, 32'h4);
      tick();
      req(1, 0, 0, '0); req(0, 1, 0, 32'h8);
      tick();
      req(0, 0, 0, '0);
      repeat (3) tick();

      // error on an m1 write response
      hold_err = 1; s_err = 1;
      req(1, 1, 1, 32'h40);
      tick();
      req(1, 0, 0, '0);
      repeat (3) tick();
      hold_err = 0;

      // reset one cycle after an m0 transfer, then a tie
      req(0, 1, 0, 32'h80);
      tick();
      req(0, 0, 0, '0); rst = 1;
      tick();
      rst = 0; req(0, 1, 0, 32'h84); req(1, 1, 0, 32'h88);
      repeat (2) tick();
      req(0, 0, 0, '0); req(1, 0, 0, '0);
      repeat (3) tick();

      // locked m0 drops vld while stalled, m1 pending
      s_rdy = 0; req(0, 1, 0, 32'hC0);
      tick();
      req(1, 1, 0, 32'hD0);
      tick();
      req(0, 0, 0, '0);
      tick();
      s_rdy = 1;
      tick();
      req(1, 0, 0, '0);
      repeat (3) tick();

      // randomized traffic; managers hold stalled requests except for rare drops
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (!(mv[i] && !done[i]) || $urandom_range(0, 49) == 0)
               req(i, $urandom_range(0, 1), $urandom_range(0, 1), 32'($urandom) & ~32'h3);
         end
         s_rdy = ($urandom_range(0, 9) < 7);
         tick();
      end
      req(0, 0, 0, '0); req(1, 0, 0, '0);
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
